// File: rtl/diamond_stream_gen.sv
// Diamond-pattern generator: streams an ASCII diamond (spaced, filled or hollow)
// one character per valid/ready beat, with a runtime half-height.
module diamond_stream_gen #(
  parameter int MAX_N = 15,
  parameter int NW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [NW-1:0] n_rows,
  input  logic [1:0]    mode,
  output logic [7:0]    char_data,
  output logic          char_valid,
  input  logic          char_ready,
  output logic          line_end,
  output logic          busy,
  output logic          done
);
  // Wide enough for 2*MAX_N so the body counter reaches 2*MAX_N-1 safely.
  localparam int CW = $clog2(2*MAX_N+1);
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_ST = 8'h2A;
  localparam logic [7:0] CH_NL = 8'h0A;

  typedef enum logic [2:0] {IDLE, LEAD, BODY, NL, FIN} state_t;

  state_t        st, nx_st;
  logic [CW-1:0] n_q, row_q, cnt_q;
  logic [1:0]    mode_q, mode_use;
  logic [CW-1:0] n_in, n_use, k_cur, k_nx, lead_nx, nx_row, nx_cnt;
  logic [7:0]    nx_char;
  logic          row_start;

  function automatic logic [CW-1:0] k_of(input logic [CW-1:0] r, input logic [CW-1:0] n);
    if (r < n) k_of = r + CW'(1);
    else       k_of = (n << 1) - r - CW'(1);
  endfunction

  assign n_in = (32'(n_rows) > MAX_N) ? CW'(MAX_N) : CW'(n_rows);

  // Position following the one currently presented (cnt_q is 1-based within
  // the lead run or the body), plus the character that goes with it.
  always_comb begin
    n_use     = (st == IDLE) ? n_in : n_q;
    mode_use  = (st == IDLE) ? mode : mode_q;
    k_cur     = k_of(row_q, n_q);
    nx_st     = st;
    nx_row    = row_q;
    nx_cnt    = cnt_q;
    row_start = 1'b0;
    case (st)
      IDLE: begin
        nx_row    = '0;
        row_start = 1'b1;
      end
      LEAD: begin
        if (cnt_q < n_q - k_cur) nx_cnt = cnt_q + CW'(1);
        else begin
          nx_st  = BODY;
          nx_cnt = CW'(1);
        end
      end
      BODY: begin
        if (cnt_q < (k_cur << 1) - CW'(1)) nx_cnt = cnt_q + CW'(1);
        else nx_st = NL;
      end
      NL: begin
        if (row_q == (n_q << 1) - CW'(2)) nx_st = FIN;
        else begin
          nx_row    = row_q + CW'(1);
          row_start = 1'b1;
        end
      end
      default: ;
    endcase
    k_nx    = k_of(nx_row, n_use);
    lead_nx = n_use - k_nx;
    if (row_start) begin
      nx_cnt = CW'(1);
      nx_st  = (lead_nx != '0) ? LEAD : BODY;
    end
    case (nx_st)
      LEAD: nx_char = CH_SP;
      NL:   nx_char = CH_NL;
      BODY: begin
        case (mode_use)
          2'd1:    nx_char = CH_ST;
          2'd2:    nx_char = (nx_cnt == CW'(1) || nx_cnt == (k_nx << 1) - CW'(1)) ? CH_ST : CH_SP;
          default: nx_char = nx_cnt[0] ? CH_ST : CH_SP;
        endcase
      end
      default: nx_char = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= IDLE;
      n_q        <= '0;
      row_q      <= '0;
      cnt_q      <= '0;
      mode_q     <= '0;
      char_data  <= 8'h00;
      char_valid <= 1'b0;
      line_end   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (abort && st != IDLE) begin
      st         <= IDLE;
      char_data  <= 8'h00;
      char_valid <= 1'b0;
      line_end   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          done <= 1'b0;
          if (start && !abort) begin
            n_q    <= n_in;
            mode_q <= mode;
            row_q  <= nx_row;
            cnt_q  <= nx_cnt;
            if (n_in == '0) begin
              st   <= FIN;
              done <= 1'b1;
            end else begin
              st         <= nx_st;
              char_data  <= nx_char;
              char_valid <= 1'b1;
              line_end   <= 1'b0;
              busy       <= 1'b1;
            end
          end
        end
        FIN: begin
          done <= 1'b0;
          st   <= IDLE;
        end
        default: begin
          if (char_ready) begin
            st    <= nx_st;
            row_q <= nx_row;
            cnt_q <= nx_cnt;
            if (nx_st == FIN) begin
              char_data  <= 8'h00;
              char_valid <= 1'b0;
              line_end   <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
            end else begin
              char_data <= nx_char;
              line_end  <= (nx_st == NL);
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_diamond_stream_gen.sv
// Scoreboarded bench: a string-building model queues the expected frame, a
// negedge monitor pops and compares every accepted beat and checks stall holds.
module tb_diamond_stream_gen;
  localparam int MAX_N = 15;
  localparam int NW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [NW-1:0] n_rows = '0;
  logic [1:0]    mode = '0;
  logic          char_ready = 1'b1;
  logic [7:0]    char_data;
  logic          char_valid, line_end, busy, done;

  int   n_asserts = 0;
  int   n_fail = 0;
  bit   rnd_ready = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_e;
  int   beats, nls, dones, linelen, maxlen;
  bit   stall_pend = 1'b0;
  logic [8:0] held;

  diamond_stream_gen #(.MAX_N(MAX_N), .NW(NW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .n_rows(n_rows), .mode(mode), .char_data(char_data),
    .char_valid(char_valid), .char_ready(char_ready),
    .line_end(line_end), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endfunction

  always @(posedge clk) begin
    #1;
    char_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (!rst_n) stall_pend = 1'b0;
    else begin
      if (done) dones++;
      if (char_valid) begin
        if (stall_pend) chk("stall_hold", {line_end, char_data}, held);
        if (char_ready) begin
          stall_pend = 1'b0;
          beats++;
          if (line_end) nls++;
          if (exp_q.size() == 0) chk("extra_beat", 1, 0);
          else begin
            mon_e = exp_q.pop_front();
            chk("char", char_data, mon_e);
            chk("line_end", line_end, mon_e == 8'h0A);
          end
          if (char_data == 8'h0A) begin
            if (linelen > maxlen) maxlen = linelen;
            linelen = 0;
          end else linelen++;
        end else begin
          stall_pend = 1'b1;
          held = {line_end, char_data};
        end
      end else stall_pend = 1'b0;
    end
  end

  task automatic push_model(input int n, input int m);
    int nn, k;
    nn = (n > MAX_N) ? MAX_N : n;
    for (int r = 0; r <= 2*nn-2; r++) begin
      k = (r < nn) ? r+1 : 2*nn-1-r;
      repeat (nn-k) exp_q.push_back(8'h20);
      for (int j = 1; j <= 2*k-1; j++) begin
        case (m)
          1:       exp_q.push_back(8'h2A);
          2:       exp_q.push_back((j == 1 || j == 2*k-1) ? 8'h2A : 8'h20);
          default: exp_q.push_back((j % 2 == 1) ? 8'h2A : 8'h20);
        endcase
      end
      exp_q.push_back(8'h0A);
    end
  endtask

  task automatic clear_counts();
    beats = 0; nls = 0; dones = 0; linelen = 0; maxlen = 0;
  endtask

  task automatic run_frame(input int n, input int m, input bit rnd, input bit mid_start,
                           input int exp_beats, input int exp_nl, input string tag);
    int nn;
    bit ended;
    nn = (n > MAX_N) ? MAX_N : n;
    ended = 1'b0;
    rnd_ready = rnd;
    clear_counts();
    push_model(n, m);
    @(posedge clk); #1;
    n_rows = NW'(n); mode = 2'(m); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, " valid_t1"}, char_valid, nn > 0);
    chk({tag, " busy_t1"}, busy, nn > 0);
    for (int c = 0; c < 5000; c++) begin
      if (!busy) begin ended = 1'b1; break; end
      start = (mid_start && c == 5);
      if (mid_start && c == 5) n_rows = 1;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk({tag, " frame_ended"}, ended, 1);
    chk({tag, " done_with_busy_fall"}, done, 1);
    chk({tag, " valid_after_end"}, char_valid, 0);
    @(posedge clk); #1;
    chk({tag, " done_one_cycle"}, done, 0);
    @(negedge clk); #1;
    chk({tag, " beats"}, beats, exp_beats);
    chk({tag, " newlines"}, nls, exp_nl);
    chk({tag, " done_count"}, dones, 1);
    chk({tag, " queue_empty"}, exp_q.size(), 0);
    rnd_ready = 1'b0;
  endtask

  task automatic cut_frame(input bit use_rst, input string tag);
    rnd_ready = 1'b0;
    clear_counts();
    push_model(4, 0);
    @(posedge clk); #1;
    n_rows = 4; mode = 0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    if (!use_rst) begin
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk({tag, " valid_dropped"}, char_valid, 0);
      chk({tag, " busy_dropped"}, busy, 0);
      chk({tag, " no_done"}, done, 0);
    end else begin
      rst_n = 1'b0;
      #1;
      chk({tag, " rst_data"}, char_data, 8'h00);
      chk({tag, " rst_valid"}, char_valid, 0);
      chk({tag, " rst_line_end"}, line_end, 0);
      chk({tag, " rst_busy"}, busy, 0);
      chk({tag, " rst_done"}, done, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
    end
    repeat (5) @(posedge clk);
    #1;
    chk({tag, " beats_before_cut"}, beats, use_rst ? 9 : 10);
    chk({tag, " dones"}, dones, 0);
    chk({tag, " stays_idle"}, {busy, char_valid}, 0);
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset char_data", char_data, 8'h00);
    chk("reset char_valid", char_valid, 0);
    chk("reset line_end", line_end, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // abort beats start in IDLE
    n_rows = 4; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("abort_start busy", busy, 0);
    chk("abort_start valid", char_valid, 0);
    chk("abort_start done", done, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_start still idle", {busy, char_valid}, 0);

    run_frame(1, 0, 0, 0, 2, 1, "n1_spaced");
    run_frame(4, 0, 0, 0, 44, 7, "n4_spaced");
    run_frame(3, 2, 1, 0, 24, 5, "n3_hollow_rnd");
    run_frame(3, 1, 0, 1, 24, 5, "n3_filled_midstart");
    run_frame(0, 0, 0, 0, 0, 0, "n0");
    run_frame(15, 0, 0, 0, 660, 29, "n15_spaced");
    chk("n15 longest_row", maxlen, 29);
    run_frame(4, 3, 1, 0, 44, 7, "n4_mode3_rnd");

    cut_frame(1'b0, "abort_b10");
    run_frame(4, 0, 0, 0, 44, 7, "after_abort");
    cut_frame(1'b1, "reset_b10");
    run_frame(4, 0, 0, 0, 44, 7, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule

// File: doc/diamond_stream_gen.md
Name: diamond_stream_gen

Overview:
- Synthesizable, parametrised diamond-pattern generator.
- Emits the pattern as an ASCII character stream over a valid/ready handshake, one character per accepted beat.
- Supports a runtime row count and three fill modes.
- Feeds a UART/console TX path in the pattern-practice subsystem, replacing simulation-only printing.

Parameters:
- MAX_N, 15: largest supported half-height (top-part row count); legal range 1..15.
- NW, 4: width of n_rows; must satisfy 2^NW > MAX_N.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a frame; sampled only in IDLE
- abort  in  1  cancel the current frame
- n_rows  in  NW  half-height N; latched on start
- mode  in  2  fill mode; latched on start
- char_data  out  8  ASCII character
- char_valid  out  1  char_data valid
- char_ready  in  1  downstream accepts the character
- line_end  out  1  high while char_data is newline (0x0A)
- busy  out  1  high from the cycle after an accepted start until the frame ends
- done  out  1  one-cycle pulse at normal frame completion

Behaviour:
- Reset values: char_data=0x00, char_valid=0, line_end=0, busy=0, done=0; FSM goes to IDLE.
- Frame geometry:
  - N = latched n_rows; values above MAX_N are clamped to MAX_N.
  - Rows r = 0..2N-2, with k = r+1 for r<N, else k = 2N-1-r.
  - Each row is: N-k spaces (0x20), then 2k-1 body chars, then 0x0A. No trailing spaces.
  - Total characters per frame = 3N^2 - N (N=1: 2; N=4: 44).
- Body char at position j = 1..2k-1:
  - mode 0 (spaced): '*' (0x2A) if j is odd, else ' '.
  - mode 1 (filled): always '*'.
  - mode 2 (hollow): '*' if j=1 or j=2k-1, else ' '.
  - mode 3: reserved, behaves as mode 0.
- FSM states: IDLE -> LEAD -> BODY -> NL -> (LEAD of next row | FIN) -> IDLE.
  - A state is skipped when its count is zero (LEAD when N-k=0).
  - FIN drives done=1 for exactly one cycle, then returns to IDLE.
- Latency: start high in IDLE at edge t gives char_valid=1 with the first character at edge t+1; busy=1 from t+1.
- Handshake:
  - A beat completes on char_valid && char_ready at a rising edge.
  - While char_valid=1 and char_ready=0, char_data and line_end hold stable.
  - With char_ready held at 1, one character is emitted per cycle with no bubbles, including across row boundaries.
- Frame end: after the final newline is accepted, char_valid=0 and busy=0 on the next edge, in the same cycle as done=1.
- start while busy: ignored, with no effect on the current frame.
- N = 0: no characters are emitted; done pulses at t+1; busy stays 0.
- abort (any state except IDLE): next edge goes to IDLE, char_valid=0, busy=0, no done. An in-flight unaccepted character is dropped.
- abort together with start in IDLE: abort wins and no frame starts.
- Asynchronous reset mid-frame: all outputs return to reset values immediately. The next frame requires a new start.
- Counters (row, leading-space, body) are sized from MAX_N. The body counter must reach 2*MAX_N-1 without overflow.

Test Plan:
- Reset, then start with n_rows=1, mode=0, char_ready=1 -> stream 0x2A, 0x0A; done pulses once; busy falls; 2 beats total.
- n_rows=4, mode=0, char_ready=1 -> 44 beats. Row 0 is "   *\n"; row 3 is "* * * *\n"; last row is "   *\n". Exactly 7 beats have line_end=1.
- n_rows=3, mode=2, char_ready driven by random 50% pattern -> rows "  *", " * *", "*   *", " * *", "  *", each terminated by 0x0A. char_data is stable on every stalled cycle and no character is lost or duplicated.
- n_rows=3, mode=1 -> middle row "*****\n"; 24 beats total. A start pulse issued mid-frame causes no restart and no extra done.
- n_rows=0 -> done at t+1 with zero valid beats. n_rows=15, mode=0 with MAX_N=15 -> 660 beats, and the longest row carries 29 body chars.
- Mid-frame abort at beat 10 of an n_rows=4 frame -> valid drops next cycle, no done. Repeating the same case with rst_n low instead -> outputs are immediately at reset values. A following start produces a full 44-beat frame.
